// File: rtl/tt_tokens_pkg.sv
// tt_tokens_pkg: shared token types and default widths for the network and its event transmitter
package tt_tokens_pkg;
  typedef enum logic [2:0] {IDLE, SETUP_ID, REQ_ID, REL_ID, SETUP_TS, REQ_TS, REL_TS} tx_state_t;
  localparam logic ID_MARKER = 1'b1;
  localparam int DEF_ID_WIDTH = 7;
  localparam int DEF_TS_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: power-of-two FIFO with same-cycle push+pop, head visible on dout
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/event_tx.sv
// event_tx: buffers network events and ships them as bytes over a 4-phase req/ack link
// Define EVENT_TX_TIMESTAMP_EN to append a tick-counter timestamp byte to every event.
module event_tx
  import tt_tokens_pkg::*;
#(
  parameter int ID_WIDTH = DEF_ID_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_WIDTH = DEF_TS_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev_valid,
  input  logic [ID_WIDTH-1:0] ev_id,
  input  logic                tick,
  output logic [7:0]          tx_data,
  output logic                tx_req,
  input  logic                tx_ack,
  output logic                fifo_full,
  output logic [7:0]          drop_cnt
);
`ifdef EVENT_TX_TIMESTAMP_EN
  localparam int EW = TS_WIDTH + ID_WIDTH;
  localparam bit TS_EN = 1'b1;
`else
  localparam int EW = ID_WIDTH;
  localparam bit TS_EN = 1'b0;
`endif
  tx_state_t state, state_n;
  logic ack_m, ack_s, push, pop, empty;
  logic [EW-1:0] din, head;
  logic [7:0] id_byte, ts_byte;
  assign push = ev_valid && (!fifo_full || pop);
  assign id_byte = {ID_MARKER, 7'(head[ID_WIDTH-1:0])};
`ifdef EVENT_TX_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt, ts_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ts_cnt <= '0;
      ts_q <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(tick);
      if (pop) ts_q <= head[EW-1:ID_WIDTH];
    end
  assign din = {ts_cnt, ev_id};
  assign ts_byte = 8'(ts_q);
`else
  logic [TS_WIDTH-1:0] unused_tick;
  assign unused_tick = {TS_WIDTH{tick}};
  assign din = ev_id;
  assign ts_byte = 8'h00;
`endif
  event_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(head), .full(fifo_full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE:     state_n = (!empty && !ack_s) ? SETUP_ID : IDLE;
      SETUP_ID: state_n = REQ_ID;
      REQ_ID: begin
        pop = ack_s;
        state_n = ack_s ? REL_ID : REQ_ID;
      end
      REL_ID:   state_n = ack_s ? REL_ID : (TS_EN ? SETUP_TS : IDLE);
      SETUP_TS: state_n = REQ_TS;
      REQ_TS:   state_n = ack_s ? REL_TS : REQ_TS;
      REL_TS:   state_n = ack_s ? REL_TS : IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // tx_data loads on entry to SETUP_* so it is settled a full cycle before req rises
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
      state <= IDLE;
      tx_req <= 1'b0;
      tx_data <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      ack_m <= tx_ack;
      ack_s <= ack_m;
      state <= state_n;
      tx_req <= state_n == REQ_ID || state_n == REQ_TS;
      tx_data <= state_n == SETUP_ID ? id_byte : state_n == SETUP_TS ? ts_byte : tx_data;
      drop_cnt <= drop_cnt + 8'(ev_valid && !push && drop_cnt != 8'hFF);
    end
endmodule
